// File: rtl/counter_monitor.sv
// Sequence monitor for a free-running counter: acquires the count, declares lock after
// LOCK_COUNT consecutive increments, and flags and counts sequence breaks while locked.
module counter_monitor #(
    parameter int          SIZE       = 10,
    parameter int          LOCK_COUNT = 4,
    parameter logic [15:0] ERR_MAX    = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_val,
    input  logic            err_clr,
    output logic            locked,
    output logic            err_pulse,
    output logic [15:0]     err_count,
    output logic [SIZE-1:0] expected
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam logic [3:0]      LOCK_N = 4'(LOCK_COUNT);
    localparam logic [SIZE-1:0] ONE    = SIZE'(1);

    state_t          state_q, state_d;
    logic [3:0]      run_q, run_d;
    logic [SIZE-1:0] exp_q, exp_d;
    logic [15:0]     err_q, err_d;
    logic            pulse_d;
    logic            locked_d;
    logic            match;
    logic            miss;

    assign match = (in_val == exp_q);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        exp_d    = exp_q;
        err_d    = err_q;
        miss     = 1'b0;
        pulse_d  = 1'b0;
        locked_d = 1'b0;

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    exp_d   = in_val + ONE;
                    run_d   = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE, LOST: begin
                    if (match) begin
                        exp_d = exp_q + ONE;
                        if (run_q + 4'd1 == LOCK_N) begin
                            run_d   = '0;
                            state_d = LOCKED;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        // resync silently; errors are only meaningful once locked
                        exp_d = in_val + ONE;
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        exp_d = exp_q + ONE;
                    end else begin
                        miss    = 1'b1;
                        exp_d   = in_val + ONE;
                        run_d   = '0;
                        state_d = LOST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pulse_d = miss;

        // a clear in the same cycle as a new error leaves exactly that error counted
        if (err_clr) begin
            err_d = miss ? 16'd1 : '0;
        end else if (miss && err_q != ERR_MAX) begin
            err_d = err_q + 16'd1;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_q     <= '0;
            exp_q     <= '0;
            err_q     <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            err_pulse <= pulse_d;
            locked    <= locked_d;
        end
    end

    assign expected  = exp_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: a lock/resync reference model predicts every
// cycle's registered outputs, and a monitor compares them after each clock edge.
module tb_counter_monitor;

    localparam int M = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, v0 = 1'b0, c0 = 1'b0;
    logic [3:0]  val0 = '0;
    logic        rst1 = 1'b1, v1 = 1'b0, c1 = 1'b0;
    logic [3:0]  val1 = '0;
    logic        lk0, p0, lk1, p1;
    logic [15:0] ec0, ec1;
    logic [3:0]  ex0, ex1;

    counter_monitor #(.SIZE(4), .LOCK_COUNT(4)) u0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .in_val(val0), .err_clr(c0),
        .locked(lk0), .err_pulse(p0), .err_count(ec0), .expected(ex0)
    );

    counter_monitor #(.SIZE(4), .LOCK_COUNT(1), .ERR_MAX(16'd20)) u1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_val(val1), .err_clr(c1),
        .locked(lk1), .err_pulse(p1), .err_count(ec1), .expected(ex1)
    );

    typedef struct {
        bit seen;
        bit lk;
        bit pulse;
        int exp;
        int run;
        int err;
    } ms_t;

    ms_t m0, m1;
    ms_t q0[$];
    ms_t q1[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Model: any sample after reset seeds the count; LOCK consecutive hits lock;
    // a miss while locked is an error, a miss while unlocked just reseeds.
    function automatic ms_t mstep(ms_t s, bit r, bit v, int val, bit clr, int lc, int mx);
        ms_t n;
        bit  miss;
        n = s;
        miss = 0;
        if (r) begin
            n.seen = 0; n.lk = 0; n.pulse = 0; n.exp = 0; n.run = 0; n.err = 0;
            return n;
        end
        if (v) begin
            if (!s.seen) begin
                n.seen = 1;
                n.exp  = (val + 1) % M;
                n.run  = 0;
            end else if (val == s.exp) begin
                n.exp = (s.exp + 1) % M;
                if (!s.lk) begin
                    n.run = s.run + 1;
                    if (n.run == lc) begin
                        n.lk  = 1;
                        n.run = 0;
                    end
                end
            end else begin
                if (s.lk) begin
                    miss = 1;
                    n.lk = 0;
                end
                n.exp = (val + 1) % M;
                n.run = 0;
            end
        end
        n.pulse = miss;
        if (clr) n.err = miss ? 1 : 0;
        else if (miss && s.err < mx) n.err = s.err + 1;
        return n;
    endfunction

    task automatic model_and_push();
        m0 = mstep(m0, rst0, v0, int'(val0), c0, 4, 65535);
        m1 = mstep(m1, rst1, v1, int'(val1), c1, 1, 20);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst0 = 1; v0 = 0; c0 = 0;
        rst1 = 1; v1 = 0; c1 = 0;
        model_and_push();
    endtask

    task automatic step(int d, bit r, bit v, int val, bit clr);
        @(negedge clk);
        if (d == 0) begin
            rst0 = r; v0 = v; val0 = 4'(val); c0 = clr;
            rst1 = 0; v1 = 0; c1 = 0;
        end else begin
            rst1 = r; v1 = v; val1 = 4'(val); c1 = clr;
            rst0 = 0; v0 = 0; c0 = 0;
        end
        model_and_push();
    endtask

    task automatic s0(bit v, int val, bit clr = 0);
        step(0, 0, v, val, clr);
    endtask

    task automatic s1(bit v, int val, bit clr = 0);
        step(1, 0, v, val, clr);
    endtask

    task automatic check(string nm, ms_t e, logic lk, logic p, logic [15:0] ec, logic [3:0] ex);
        vectors++;
        if (lk !== e.lk || p !== e.pulse || ec !== 16'(e.err) || ex !== 4'(e.exp)) begin
            miscompares++;
            $display("FAIL %s @%0t: got locked=%0b err_pulse=%0b err_count=%0d expected=%0d, want locked=%0b err_pulse=%0b err_count=%0d expected=%0d",
                     nm, $time, lk, p, ec, ex, e.lk, e.pulse, e.err, e.exp);
        end
    endtask

    initial begin
        ms_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dut0", e, lk0, p0, ec0, ex0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1", e, lk1, p1, ec1, ex1);
            end
        end
    end

    initial begin
        bit r, v, c;
        int sel, val;

        reset_all();
        reset_all();

        for (int i = 3; i <= 7; i++) s0(1, i);
        for (int i = 8; i <= 13; i++) s0(1, i);
        s0(1, 14); s0(1, 15); s0(1, 0); s0(1, 1);

        step(0, 1, 1, 9, 1);
        for (int i = 4; i <= 8; i++) s0(1, i);
        s0(1, 11);
        for (int i = 12; i <= 15; i++) s0(1, i);

        for (int i = 0; i < 10; i++) s0(0, 7);
        s0(1, 0);
        s0(1, 1);
        s0(1, 1);
        for (int i = 2; i <= 5; i++) s0(1, i);
        s0(1, 9, 1);
        s0(0, 0, 1);
        for (int i = 10; i <= 13; i++) s0(1, i);
        step(0, 1, 0, 0, 0);
        s0(1, 5);
        s0(1, 6);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 8);
            c   = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)       val = m0.exp;
            else if (sel == 7) val = (m0.exp + M - 1) % M;
            else               val = $urandom_range(0, M - 1);
            step(0, r, v, val, c);
        end

        s1(1, 0);
        s1(1, 1);
        for (int i = 0; i < 25; i++) begin
            s1(1, (m1.exp + 5) % M);
            s1(1, m1.exp);
        end
        s1(1, (m1.exp + 3) % M, 1);
        s1(1, m1.exp);
        s1(1, (m1.exp + 7) % M);

        repeat (3) @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
